// File: rtl/dmem_bus_if.sv
// Data-memory bus interface: turns single-cycle datapath load/store strobes into
// a valid/ack bus transaction and stalls the core until it completes or faults.
module dmem_bus_if #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        byte_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  input  logic        err_clr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    lane;
  logic          byte_q;

  logic          req_any;
  logic          misaligned;
  logic          dual;
  logic [3:0]    dec_be;
  logic [31:0]   dec_wdata;
  logic [7:0]    lane_byte;

  logic          issue;
  logic          fault;
  logic          complete;
  logic          expire;
  logic          err_set;

  // Request decode from the current instruction's strobes and address.
  always_comb begin
    req_any    = mem_rd | mem_wr;
    dual       = mem_rd & mem_wr;
    misaligned = ~byte_sel & (addr[1:0] != 2'b00);
    dec_be     = byte_sel ? (4'b0001 << addr[1:0]) : 4'b1111;
    dec_wdata  = byte_sel ? {4{wdata[7:0]}} : wdata;
  end

  // Byte lane of the returned bus word selected by the latched address.
  always_comb begin
    lane_byte = bus_rdata[7:0];
    case (lane)
      2'd0:    lane_byte = bus_rdata[7:0];
      2'd1:    lane_byte = bus_rdata[15:8];
      2'd2:    lane_byte = bus_rdata[23:16];
      default: lane_byte = bus_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and the combinational stall seen by the PC/register file.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue     = 1'b0;
    fault     = 1'b0;
    complete  = 1'b0;
    expire    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          stall   = 1'b1;
          err_set = misaligned | dual;
          if (misaligned) begin
            fault     = 1'b1;
            state_nxt = DONE;
          end else begin
            issue     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          expire    = 1'b1;
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request outputs: captured at issue, held stable until the access ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      lane      <= 2'd0;
      byte_q    <= 1'b0;
    end else if (issue) begin
      bus_req   <= 1'b1;
      bus_we    <= mem_wr;
      bus_addr  <= {addr[31:2], 2'b00};
      bus_be    <= dec_be;
      bus_wdata <= dec_wdata;
      lane      <= addr[1:0];
      byte_q    <= byte_sel;
    end else if (complete | expire) begin
      bus_req   <= 1'b0;
    end
  end

  // Ack-wait counter restarts on every issue and saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  cnt <= '0;
    else if (issue)                             cnt <= '0;
    else if ((state == REQ) && (cnt != CNT_MAX)) cnt <= cnt + CW'(1);
  end

  // Load data changes only when an access finishes or faults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= 32'h0;
    end else if (fault && !mem_wr) begin
      rdata <= ERR_DATA;
    end else if (complete && !bus_we) begin
      rdata <= byte_q ? {24'h0, lane_byte} : bus_rdata;
    end else if (expire && !bus_we) begin
      rdata <= ERR_DATA;
    end
  end

  // Sticky fault flag; a new fault beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Scoreboard bench for dmem_bus_if: a memory-level reference model predicts each
// access outcome, a bus responder emulates memory, a monitor checks completions.
module tb_dmem_bus_if;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_0BAD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_rd = 1'b0, mem_wr = 1'b0, byte_sel = 1'b0, err_clr = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  dmem_bus_if #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .byte_sel(byte_sel), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .err(err), .err_clr(err_clr), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          has_bus;
    bit          we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] rdata;
    bit          err;
    int          stall_cyc;
    int          req_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          delay_q[$];
  bit   [31:0] ref_mem[0:1023];
  bit   [31:0] bus_mem[0:1023];
  logic [31:0] model_rdata = 32'h0;
  bit          model_err = 1'b0;
  int          nchk = 0;
  int          nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus responder: acks after the delay chosen by the stimulus, acts as memory.
  int rsp_d = 0, rsp_cnt = 0;
  bit rsp_active = 1'b0;
  always @(negedge clk) begin
    bus_ack = 1'b0;
    if (reset) begin
      rsp_active = 1'b0;
    end else if (bus_req) begin
      if (!rsp_active) begin
        rsp_active = 1'b1;
        rsp_cnt    = 0;
        rsp_d      = (delay_q.size() != 0) ? delay_q.pop_front() : 99;
      end
      if (rsp_cnt == rsp_d) begin
        bus_ack    = 1'b1;
        bus_rdata  = bus_mem[bus_addr[11:2]];
        if (bus_we)
          for (int b = 0; b < 4; b++)
            if (bus_be[b]) bus_mem[bus_addr[11:2]][8*b +: 8] = bus_wdata[8*b +: 8];
        rsp_active = 1'b0;
      end else begin
        bus_rdata = $urandom;
        rsp_cnt++;
      end
    end else if (rsp_active || ($urandom_range(0, 3) == 0)) begin
      // Late or spurious ack while no request is outstanding.
      rsp_active = 1'b0;
      bus_ack    = 1'b1;
      bus_rdata  = $urandom;
    end
  end

  // Monitor: counts stall/bus cycles per access and scores each completion.
  int          st_cnt = 0, rq_cnt = 0;
  bit          stable = 1'b1;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  exp_t        e;
  always @(negedge clk) begin
    if (reset || !(mem_rd || mem_wr)) begin
      st_cnt = 0; rq_cnt = 0; stable = 1'b1;
    end else if (stall) begin
      st_cnt++;
      if (bus_req) begin
        if (rq_cnt == 0) begin
          cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
        end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata ||
                     bus_be !== cap_be || bus_we !== cap_we) begin
          stable = 1'b0;
        end
        rq_cnt++;
      end
    end else begin
      if (exp_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_completion: got completion expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("err", 32'(err), 32'(e.err));
        check("stall_cycles", 32'(st_cnt), 32'(e.stall_cyc));
        check("req_cycles", 32'(rq_cnt), 32'(e.req_cyc));
        check("bus_req_in_done", 32'(bus_req), 32'h0);
        if (e.has_bus) begin
          check("bus_addr", cap_addr, e.baddr);
          check("bus_be", 32'(cap_be), 32'(e.be));
          check("bus_we", 32'(cap_we), 32'(e.we));
          check("bus_wdata", cap_wdata, e.bwdata);
          check("bus_stable", 32'(stable), 32'h1);
        end
      end
      st_cnt = 0; rq_cnt = 0; stable = 1'b1;
    end
  end

  // One memory instruction: predict the outcome, drive it, hold until DONE.
  task automatic do_access(input bit rd, input bit wr, input bit bsel,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int d, input bit clr);
    exp_t x;
    int   lane, idx;
    bit   flt, tmo, done;
    lane = int'(a[1:0]);
    idx  = int'(a[11:2]);
    flt  = !bsel && (lane != 0);
    tmo  = !flt && (d >= int'(TO));
    x.has_bus   = !flt;
    x.we        = wr;
    x.baddr     = a - 32'(lane);
    x.be        = bsel ? 4'(1 << lane) : 4'hF;
    x.bwdata    = bsel ? wd[7:0] * 32'h0101_0101 : wd;
    x.req_cyc   = flt ? 0 : (tmo ? int'(TO) : d + 1);
    x.stall_cyc = 1 + x.req_cyc;
    if (!flt && !tmo) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (x.be[b]) ref_mem[idx][8*b +: 8] = x.bwdata[8*b +: 8];
      end else begin
        model_rdata = bsel ? ((ref_mem[idx] >> (8 * lane)) & 32'hFF) : ref_mem[idx];
      end
    end else if (!wr) begin
      model_rdata = ERRD;
    end
    x.rdata = model_rdata;
    if (clr) begin
      x.err     = flt || tmo;
      model_err = 1'b0;
    end else begin
      x.err     = model_err || (rd && wr) || flt || tmo;
      model_err = x.err;
    end
    exp_q.push_back(x);
    if (!flt) delay_q.push_back(d);

    mem_rd = rd; mem_wr = wr; byte_sel = bsel; addr = a; wdata = wd; err_clr = clr;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      nchk++; nerr++;
      $display("FAIL access_hang: got stall stuck high expected DONE (addr=%h)", a);
    end
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rd, wr, bsel;
    logic [31:0] a;
    int k;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[10'h040] = 32'hCAFE_F00D; bus_mem[10'h040] = 32'hCAFE_F00D;
    ref_mem[10'h000] = 32'h1122_3344; bus_mem[10'h000] = 32'h1122_3344;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_bus_we", 32'(bus_we), 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", 32'(bus_be), 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    do_access(1, 0, 0, 32'h0000_0100, 32'h0, 0, 0);
    do_access(0, 1, 1, 32'h0000_0203, 32'h1234_56A5, 0, 0);
    do_access(1, 0, 1, 32'h0000_0002, 32'h0, 1, 0);
    do_access(1, 0, 0, 32'h0000_0101, 32'h0, 0, 0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    check("err_after_clr", 32'(err), 32'h0);
    @(posedge clk); #1;
    do_access(1, 0, 0, 32'h0000_0104, 32'h0, 7, 0);
    idle(2);
    do_access(1, 0, 0, 32'h0000_0200, 32'h0, 2, 1);
    do_access(1, 0, 1, 32'h0000_0203, 32'h0, 3, 0);

    for (int n = 0; n < 200; n++) begin
      k    = $urandom_range(0, 7);
      rd   = (k <= 3) || (k == 7);
      wr   = (k >= 4);
      bsel = $urandom_range(0, 1) == 1;
      a    = 32'($urandom_range(0, 4095));
      if (!bsel && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_access(rd, wr, bsel, a, $urandom, $urandom_range(0, 5),
                $urandom_range(0, 7) == 0);
      idle($urandom_range(0, 2));
    end

    // Reset in the middle of an outstanding request.
    delay_q.push_back(99);
    mem_rd = 1'b1; byte_sel = 1'b0; addr = 32'h0000_0040;
    @(negedge clk);
    @(negedge clk);
    check("req_before_reset", 32'(bus_req), 32'h1);
    #1;
    reset = 1'b1; mem_rd = 1'b0;
    #1;
    check("req_async_drop", 32'(bus_req), 32'h0);
    check("rdata_async_clr", rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_rdata = 32'h0;
    model_err   = 1'b0;
    idle(1);
    do_access(1, 0, 0, 32'h0000_0100, 32'h0, 0, 0);
    do_access(1, 0, 0, 32'h0000_0000, 32'h0, 0, 0);
    do_access(1, 0, 1, 32'h0000_0001, 32'h0, 1, 0);
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
- Data-memory bus interface directly downstream of the single-cycle datapath.
- Consumes the datapath's ALUResult (address) and WriteData, plus the controller's memory strobes.
- Runs a valid/ack transaction on the external data bus and returns ReadData to the datapath's result mux.
- Raises stall so the PC register and register-file write hold until the access completes, which gives the CPU variable-latency memory.

Parameters:
- TIMEOUT, 16: max cycles bus_req waits for bus_ack before the access is aborted. Range 2..255.
- ERR_DATA, 32'h0000_0000: value returned on rdata for a faulted read.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_rd  in  1  load request (LDR/LDRB) for the current instruction.
- mem_wr  in  1  store request (STR/STRB) for the current instruction.
- byte_sel  in  1  1 = byte access, 0 = word access.
- addr  in  32  byte address (datapath ALUResult).
- wdata  in  32  store data (datapath WriteData).
- rdata  out  32  load data to the datapath ReadData.
- stall  out  1  freeze PC and register-file write while high.
- err  out  1  sticky fault flag.
- err_clr  in  1  synchronous clear of err.
- bus_req  out  1  bus transaction valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_be  out  4  byte lane enables.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  transaction complete, single-cycle pulse.

Behaviour:
- Reset (async): state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rdata=0, err=0, timeout counter=0. A reset during REQ drops bus_req immediately; a bus_ack that arrives later is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - With no request, stall=0.
  - If mem_rd|mem_wr, stall=1 combinationally in the same cycle.
  - Valid request: latch bus_addr, bus_we, bus_be, bus_wdata; go to REQ.
  - Fault request: set err, go to DONE without touching the bus.
- Request decode:
  - mem_wr has priority if both strobes are high; this case also sets err, but the write is still performed.
  - Word access: bus_be=4'b1111, bus_wdata=wdata.
  - Byte access: bus_be=4'b0001<<addr[1:0], bus_wdata={4{wdata[7:0]}}.
  - Word access with addr[1:0]!=0 is a fault: no bus cycle; reads return ERR_DATA.
- REQ:
  - bus_req=1 and stall=1. Bus outputs stay stable until ack.
  - Timeout counter increments each cycle.
  - On bus_ack: capture the read result into rdata, go to DONE.
    - Word read: rdata=bus_rdata.
    - Byte read: rdata = zero-extended lane addr[1:0] of bus_rdata.
    - Write: rdata unchanged.
  - If the counter reaches TIMEOUT-1 without ack: drop bus_req, set err, rdata=ERR_DATA (reads), go to DONE.
  - bus_ack outside REQ is ignored.
- DONE:
  - stall=0 and bus_req=0; rdata is held. The datapath completes the instruction at this clock edge.
  - Always returns to IDLE. It must not re-issue even though mem_rd/mem_wr for the same instruction are still high.
- Latency:
  - Access with ack in the first REQ cycle: stall high for 2 cycles (IDLE, REQ), low in DONE. Total 3 cycles per memory instruction.
  - Non-memory instructions: 0 added cycles.
- rdata changes only on the IDLE->DONE fault path or on REQ exit.
- err_clr: err=0 on the next edge unless a new fault is set in that same cycle; set wins.
- Counter is 8 bits, reset on entry to REQ, never wraps.

Test Plan:
- Word read, ack after 1 REQ cycle: addr=0x100, bus_rdata=0xCAFEF00D -> bus_addr=0x100, be=1111, stall high 2 cycles, rdata=0xCAFEF00D in DONE, err=0.
- Byte store: addr=0x203, wdata=0x123456A5, byte_sel=1 -> bus_addr=0x200, be=1000, bus_wdata=0xA5A5A5A5, bus_we=1.
- Byte read lane 2: addr=0x02, bus_rdata=0x11223344 -> rdata=0x00000022.
- Misaligned word read: addr=0x101 -> bus_req never asserted, stall high 1 cycle, rdata=0, err=1; err_clr pulse -> err=0.
- Timeout with TIMEOUT=4 and ack held low: bus_req high exactly 4 cycles, then err=1, rdata=0, stall drops. A late ack in IDLE has no effect.
- Reset asserted mid-REQ: bus_req falls asynchronously, before the next edge. After release, a new read with immediate ack completes normally. Back-to-back reads re-enter REQ from IDLE with no dropped or duplicate transaction.
